// File: rtl/pit_wb_slave_if.sv
// pit_wb_slave_if: parametrised WISHBONE slave front-end for the PIT register bytes
module pit_wb_slave_if #(
  parameter int DWIDTH      = 16,
  parameter int AWIDTH      = 3,
  parameter int NREGS       = 6,
  parameter int WAIT_STATES = 1,
  parameter int ERR_EN      = 1
) (
  input  logic                  wb_clk_i,
  input  logic                  arst_i,
  input  logic                  wb_rst_i,
  input  logic [AWIDTH-1:0]     wb_adr_i,
  input  logic [DWIDTH-1:0]     wb_dat_i,
  output logic [DWIDTH-1:0]     wb_dat_o,
  input  logic                  wb_we_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_cyc_i,
  input  logic [DWIDTH/8-1:0]   wb_sel_i,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic [NREGS-1:0]      write_regs,
  input  logic [8*NREGS-1:0]    read_regs
);
  localparam int B  = DWIDTH / 8;
  localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

  logic sel;
  logic unused_ok;

  assign sel       = wb_cyc_i & wb_stb_i;
  // write data is consumed by the register blocks, not by this front-end
  assign unused_ok = ^{wb_dat_i, wb_clk_i, arst_i, wb_rst_i};

  function automatic logic oor(input logic [AWIDTH-1:0] a);
    return (int'(a) * B) >= NREGS;
  endfunction

  // lanes past the last register byte read as zero, so a fully oor word reads zero too
  function automatic logic [DWIDTH-1:0] rd_word(input logic [AWIDTH-1:0] a,
                                                input logic [8*NREGS-1:0] rr);
    logic [DWIDTH-1:0] w;
    w = '0;
    for (int j = 0; j < B; j++) begin
      int k;
      k = int'(a) * B + j;
      if (k < NREGS) w[8*j +: 8] = rr[8*k +: 8];
    end
    return w;
  endfunction

  function automatic logic [NREGS-1:0] wr_mask(input logic [AWIDTH-1:0] a,
                                               input logic [B-1:0] s);
    logic [NREGS-1:0] m;
    for (int k = 0; k < NREGS; k++) m[k] = ((k / B) == int'(a)) && s[k % B];
    return m;
  endfunction

  generate
    if (WAIT_STATES == 0) begin : g_comb
      logic err_c;
      // zero-wait-state: everything decoded from the live bus every cycle
      always_comb begin
        err_c      = (ERR_EN != 0) && oor(wb_adr_i);
        wb_ack_o   = sel & ~err_c;
        wb_err_o   = sel & err_c;
        wb_dat_o   = rd_word(wb_adr_i, read_regs);
        write_regs = (sel & wb_we_i & ~err_c) ? wr_mask(wb_adr_i, wb_sel_i) : '0;
      end
    end else begin : g_fsm
      typedef enum logic [1:0] {IDLE, WAIT, TERM} state_t;
      state_t            state_q, state_d;
      logic [CW-1:0]     cnt_q, cnt_d;
      logic [AWIDTH-1:0] adr_q, adr_d;
      logic              we_q, we_d;
      logic [B-1:0]      sel_q, sel_d;
      logic [DWIDTH-1:0] dat_q, dat_d;
      logic              err_c, term;

      // next-state: latch the request in IDLE, count wait states, abort on strobe loss
      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        we_d    = we_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        case (state_q)
          IDLE: if (sel) begin
            adr_d   = wb_adr_i;
            we_d    = wb_we_i;
            sel_d   = wb_sel_i;
            cnt_d   = CW'(WAIT_STATES - 1);
            state_d = (WAIT_STATES == 1) ? TERM : WAIT;
          end
          WAIT: if (!sel) state_d = IDLE;
                else begin
                  cnt_d   = cnt_q - CW'(1);
                  state_d = (cnt_q == CW'(1)) ? TERM : WAIT;
                end
          default: state_d = IDLE;
        endcase
        if (state_d == TERM) dat_d = rd_word(adr_d, read_regs);
      end

      // state and request registers; async and sync resets both return to IDLE
      always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
          state_q <= IDLE;
          cnt_q   <= '0;
          adr_q   <= '0;
          we_q    <= 1'b0;
          sel_q   <= '0;
          dat_q   <= '0;
        end else if (wb_rst_i) begin
          state_q <= IDLE;
          cnt_q   <= '0;
          adr_q   <= '0;
          we_q    <= 1'b0;
          sel_q   <= '0;
          dat_q   <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          adr_q   <= adr_d;
          we_q    <= we_d;
          sel_q   <= sel_d;
          dat_q   <= dat_d;
        end
      end

      // terminations gated by the live strobe so an abort in TERM issues nothing
      always_comb begin
        err_c      = (ERR_EN != 0) && oor(adr_q);
        term       = (state_q == TERM) & sel;
        wb_ack_o   = term & ~err_c;
        wb_err_o   = term & err_c;
        wb_dat_o   = dat_q;
        write_regs = (term & we_q & ~err_c) ? wr_mask(adr_q, sel_q) : '0;
      end
    end
  endgenerate
endmodule

// File: tb/tb_pit_wb_slave_if.sv
// tb_pit_wb_slave_if: three configurations of the PIT bus front-end against a cycle-level reference model
module tb_pit_wb_slave_if;
  logic        clk = 1'b0;
  logic        arst = 1'b0;
  logic        srst = 1'b0;
  logic [2:0]  adr = '0;
  logic [31:0] dat = '0;
  logic        we = 1'b0, stb = 1'b0, cyc = 1'b0;
  logic [3:0]  sel = '0;
  logic [47:0] rr = '0;

  logic [15:0] dat_a, dat_b;
  logic [31:0] dat_c;
  logic        ack_a, err_a, ack_b, err_b, ack_c, err_c;
  logic [5:0]  wr_a, wr_b, wr_c;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pit_wb_slave_if #(.DWIDTH(16), .AWIDTH(3), .NREGS(6), .WAIT_STATES(1), .ERR_EN(1)) dut_a (
    .wb_clk_i(clk), .arst_i(arst), .wb_rst_i(srst), .wb_adr_i(adr), .wb_dat_i(dat[15:0]),
    .wb_dat_o(dat_a), .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_sel_i(sel[1:0]),
    .wb_ack_o(ack_a), .wb_err_o(err_a), .write_regs(wr_a), .read_regs(rr));

  pit_wb_slave_if #(.DWIDTH(16), .AWIDTH(3), .NREGS(6), .WAIT_STATES(3), .ERR_EN(0)) dut_b (
    .wb_clk_i(clk), .arst_i(arst), .wb_rst_i(srst), .wb_adr_i(adr), .wb_dat_i(dat[15:0]),
    .wb_dat_o(dat_b), .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_sel_i(sel[1:0]),
    .wb_ack_o(ack_b), .wb_err_o(err_b), .write_regs(wr_b), .read_regs(rr));

  pit_wb_slave_if #(.DWIDTH(32), .AWIDTH(3), .NREGS(6), .WAIT_STATES(0), .ERR_EN(1)) dut_c (
    .wb_clk_i(clk), .arst_i(arst), .wb_rst_i(srst), .wb_adr_i(adr), .wb_dat_i(dat),
    .wb_dat_o(dat_c), .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_sel_i(sel),
    .wb_ack_o(ack_c), .wb_err_o(err_c), .write_regs(wr_c), .read_regs(rr));

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // register file seen as a byte array; bytes past the sixth read as zero
  function automatic logic [31:0] exp_rd(input int b, input int a, input logic [47:0] r);
    logic [7:0] bytes [32];
    logic [31:0] w;
    for (int k = 0; k < 32; k++) bytes[k] = (k < 6) ? r[8*k +: 8] : 8'h00;
    w = '0;
    for (int j = 0; j < b; j++) w[8*j +: 8] = bytes[a*b + j];
    return w;
  endfunction

  function automatic logic [5:0] exp_mask(input int b, input int a, input logic [3:0] s);
    logic [5:0] m;
    m = '0;
    for (int k = 0; k < 6; k++) if (k / b == a && s[k % b]) m[k] = 1'b1;
    return m;
  endfunction

  // with the strobe held from IDLE, a config with ws wait states terminates every ws+1 cycles
  task automatic chk_cfg(input string nm, input int ws, input int b, input bit ee, input int n,
                         input logic ack, input logic err, input logic [5:0] wr,
                         input logic [31:0] d, input int a, input logic [3:0] s,
                         input logic w, input logic [47:0] r);
    bit term, ec;
    term = (n % (ws + 1)) == 0;
    ec   = ee && (a * b >= 6);
    chk({nm, "_ack"}, ack, term && !ec);
    chk({nm, "_err"}, err, term && ec);
    chk({nm, "_wr"}, wr, (term && w && !ec) ? exp_mask(b, a, s) : 6'h00);
    if (term) chk({nm, "_dat"}, d, exp_rd(b, a, r));
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_ack_a"}, ack_a, 1'b0);
    chk({nm, "_err_a"}, err_a, 1'b0);
    chk({nm, "_wr_a"}, wr_a, 6'h00);
    chk({nm, "_ack_b"}, ack_b, 1'b0);
    chk({nm, "_err_b"}, err_b, 1'b0);
    chk({nm, "_wr_b"}, wr_b, 6'h00);
    chk({nm, "_ack_c"}, ack_c, 1'b0);
    chk({nm, "_err_c"}, err_c, 1'b0);
    chk({nm, "_wr_c"}, wr_c, 6'h00);
  endtask

  task automatic burst(input logic [2:0] a, input logic [3:0] s, input logic w,
                       input logic [47:0] r, input int len);
    @(posedge clk) #1;
    adr = a; sel = s; we = w; rr = r; dat = $urandom; cyc = 1'b1; stb = 1'b1;
    for (int n = 1; n <= len; n++) begin
      @(negedge clk);
      chk_cfg("a", 1, 2, 1'b1, n, ack_a, err_a, wr_a, {16'h0, dat_a}, int'(a), s, w, r);
      chk_cfg("b", 3, 2, 1'b0, n, ack_b, err_b, wr_b, {16'h0, dat_b}, int'(a), s, w, r);
      chk_cfg("c", 0, 4, 1'b1, n, ack_c, err_c, wr_c, dat_c, int'(a), s, w, r);
      if (n < len) @(posedge clk) #1;
    end
    @(posedge clk) #1;
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    chk_idle("gap");
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle("rst");
    chk("rst_dat_a", dat_a, 16'h0);
    chk("rst_dat_b", dat_b, 16'h0);
    chk("rst_dat_c", dat_c, 32'h0);
    arst = 1'b1;
    burst(3'd1, 4'b0011, 1'b1, 48'h1122_3344_5566, 2);
    burst(3'd2, 4'b0011, 1'b0, 48'hBEEF_0000_0000, 2);
    chk("beef_a", dat_a, 16'hBEEF);
    @(posedge clk) #1 srst = 1'b1;
    @(posedge clk) #1 srst = 1'b0;
    @(negedge clk);
    chk("srst_dat_a", dat_a, 16'h0);
    burst(3'd0, 4'b0010, 1'b1, 48'hA1B2_C3D4_E5F6, 4);
    burst(3'd3, 4'b0011, 1'b1, 48'h0123_4567_89AB, 4);
    burst(3'd3, 4'b0011, 1'b0, 48'hFFFF_FFFF_FFFF, 4);
    burst(3'd1, 4'b0011, 1'b1, 48'h0F0F_F0F0_5A5A, 2);
    burst(3'd1, 4'b0001, 1'b1, 48'h0F0F_F0F0_5A5A, 4);
    // back-to-back zero-wait writes on the 32-bit config
    @(posedge clk) #1;
    adr = 3'd0; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    chk("b2b0_ack_c", ack_c, 1'b1);
    chk("b2b0_wr_c", wr_c, 6'h0F);
    @(posedge clk) #1 adr = 3'd1;
    @(negedge clk);
    chk("b2b1_ack_c", ack_c, 1'b1);
    chk("b2b1_wr_c", wr_c, 6'h30);
    @(posedge clk) #1;
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    chk_idle("b2b_gap");
    // async reset in the middle of a termination
    @(posedge clk) #1;
    adr = 3'd1; sel = 4'b0011; we = 1'b1; rr = 48'h7766_5544_3322; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    @(posedge clk) #1;
    chk("arst_pre_ack_a", ack_a, 1'b1);
    chk("arst_pre_wr_a", wr_a, 6'b001100);
    arst = 1'b0;
    #1;
    chk("arst_ack_a", ack_a, 1'b0);
    chk("arst_wr_a", wr_a, 6'h00);
    chk("arst_dat_a", dat_a, 16'h0);
    chk("arst_ack_b", ack_b, 1'b0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk) arst = 1'b1;
    burst(3'd2, 4'b0011, 1'b0, 48'hCAFE_1234_5678, 4);
    for (int t = 0; t < 40; t++)
      burst(3'($urandom_range(0, 7)), 4'($urandom), 1'($urandom),
            {16'($urandom), 32'($urandom)}, $urandom_range(1, 9));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
